// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame-format codes and helpers
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5,
    ST_BREAK  = 3'd6
  } uart_state_t;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam logic [1:0] STOP_1     = 2'b00;
  localparam logic [1:0] STOP_1_5   = 2'b01;
  localparam logic [1:0] STOP_2     = 2'b10;
  localparam logic [1:0] STOP_2_ALT = 2'b11;

  // Number of data bits N carried by a frame for a given data_bits code.
  function automatic int data_len(input logic [1:0] data_bits);
    return 5 + int'(data_bits);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - request/config and serial-line bundle of the UART transmitter
interface uart_tx_cfg_if #(parameter int DBITS_MAX = 8);
  logic                 s_tick;
  logic                 tx_start;
  logic [DBITS_MAX-1:0] din;
  logic [1:0]           data_bits;
  logic [1:0]           parity_mode;
  logic [1:0]           stop_bits;
  logic                 send_break;
  logic                 tx;
  logic                 tx_done;
  logic                 tx_idle;

  modport master (
    output s_tick, tx_start, din, data_bits, parity_mode, stop_bits, send_break,
    input  tx, tx_done, tx_idle
  );

  modport slave (
    input  s_tick, tx_start, din, data_bits, parity_mode, stop_bits, send_break,
    output tx, tx_done, tx_idle
  );
endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - counts s_tick up to a loaded terminal count and flags the bit end
module uart_bit_timer #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          s_tick,
  input  logic [TW-1:0] last_cnt,
  output logic          bit_end
);

  logic [TW-1:0] cnt;

  // last_cnt is the terminal count minus one so 2*OVS-1 still fits in TW bits.
  assign bit_end = s_tick && !clr && (cnt == last_cnt);

  always_ff @(posedge clk) begin
    if (rst || clr || bit_end) begin
      cnt <= '0;
    end else if (s_tick) begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter (5-8 data bits, parity, 1/1.5/2 stop, break)
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DBITS_MAX = 8,
  parameter int OVS       = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_cfg_if.slave  bus
);

  localparam int TW = $clog2(2 * OVS);
  localparam int BW = (DBITS_MAX > 1) ? $clog2(DBITS_MAX) : 1;

  uart_state_t          state;
  logic [DBITS_MAX-1:0] data_reg;
  logic [DBITS_MAX-1:0] din_masked;
  logic [1:0]           bits_reg;
  logic [1:0]           par_reg;
  logic [1:0]           stop_reg;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        next_idx;
  logic [TW-1:0]        last_cnt;
  logic                 timer_clr;
  logic                 bit_end;
  logic                 par_en;
  logic                 par_bit;
  logic                 last_bit;
  logic                 tx_q;
  logic                 tx_done_q;
  logic                 tx_idle_q;

  assign bus.tx      = tx_q;
  assign bus.tx_done = tx_done_q;
  assign bus.tx_idle = tx_idle_q;

  // Unsent high bits are zeroed at latch time so parity is a plain XOR of the register.
  always_comb begin
    din_masked = '0;
    for (int i = 0; i < DBITS_MAX; i++) begin
      din_masked[i] = bus.din[i] & (i < data_len(bus.data_bits));
    end
  end

  always_comb begin
    last_cnt = TW'(OVS - 1);
    if (state == ST_STOP) begin
      case (stop_reg)
        STOP_1:   last_cnt = TW'(OVS - 1);
        STOP_1_5: last_cnt = TW'(OVS * 3 / 2 - 1);
        default:  last_cnt = TW'(2 * OVS - 1);
      endcase
    end
  end

  assign timer_clr = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_BREAK);
  assign par_en    = (par_reg == PAR_EVEN) || (par_reg == PAR_ODD);
  assign par_bit   = (^data_reg) ^ (par_reg == PAR_ODD);
  assign last_bit  = (int'(bit_cnt) == data_len(bits_reg) - 1);
  assign next_idx  = bit_cnt + BW'(1);

  uart_bit_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .s_tick   (bus.s_tick),
    .last_cnt (last_cnt),
    .bit_end  (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      data_reg  <= '0;
      bits_reg  <= DBITS_5;
      par_reg   <= PAR_NONE;
      stop_reg  <= STOP_1;
      bit_cnt   <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
      tx_idle_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_q      <= 1'b1;
          tx_idle_q <= 1'b1;
          tx_done_q <= 1'b0;
          if (bus.tx_start) begin
            data_reg  <= din_masked;
            bits_reg  <= bus.data_bits;
            par_reg   <= bus.parity_mode;
            stop_reg  <= bus.stop_bits;
            bit_cnt   <= '0;
            tx_q      <= 1'b0;
            tx_idle_q <= 1'b0;
            state     <= ST_START;
          end else if (bus.send_break) begin
            tx_q      <= 1'b0;
            tx_idle_q <= 1'b0;
            state     <= ST_BREAK;
          end
        end
        ST_START: begin
          if (bit_end) begin
            tx_q  <= data_reg[0];
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (last_bit) begin
              bit_cnt <= '0;
              if (par_en) begin
                tx_q  <= par_bit;
                state <= ST_PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              bit_cnt <= next_idx;
              tx_q    <= data_reg[next_idx];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            tx_q  <= 1'b1;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            tx_done_q <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          tx_done_q <= 1'b0;
          tx_idle_q <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_BREAK: begin
          // Leaving a break always emits one bit of mark before going idle.
          if (!bus.send_break) begin
            tx_q     <= 1'b1;
            stop_reg <= STOP_1;
            state    <= ST_STOP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg against a per-tick line model
module tb_uart_tx_cfg;

  localparam int OVS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   exp_q[$];

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DBITS_MAX(8)) bus ();

  uart_tx_cfg #(.DBITS_MAX(8), .OVS(OVS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Line level expected during each s_tick of a frame, from the frame-format rules.
  task automatic build(input logic [7:0] d, input logic [1:0] db, input logic [1:0] pm,
                       input logic [1:0] sb);
    int n;
    bit p;
    int stop_ticks;
    exp_q.delete();
    n = 5 + int'(db);
    p = 1'b0;
    repeat (OVS) exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      repeat (OVS) exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pm == 2'b01) repeat (OVS) exp_q.push_back(p);
    if (pm == 2'b10) repeat (OVS) exp_q.push_back(~p);
    stop_ticks = (sb == 2'b00) ? OVS : (sb == 2'b01) ? (OVS * 3) / 2 : 2 * OVS;
    repeat (stop_ticks) exp_q.push_back(1'b1);
  endtask

  // Plays exp_q tick by tick with random gaps; returns the number of line/tx_done mismatches.
  task automatic play(input bit disturb, output int werr);
    werr = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if (bus.tx !== exp_q[k] || bus.tx_done !== 1'b0) werr++;
        @(negedge clk);
      end
      if (disturb) begin
        if (k < exp_q.size() - 1) begin
          bus.tx_start    = 1'($urandom);
          bus.din         = 8'($urandom);
          bus.data_bits   = 2'($urandom);
          bus.parity_mode = 2'($urandom);
          bus.stop_bits   = 2'($urandom);
        end else begin
          bus.tx_start = 1'b0;
        end
      end
      bus.s_tick = 1'b1;
      if (bus.tx !== exp_q[k] || bus.tx_done !== 1'b0) werr++;
      @(negedge clk);
      bus.s_tick = 1'b0;
    end
  endtask

  task automatic finish_check(input string tag);
    chk({tag, "_done_hi"}, 32'(bus.tx_done), 32'd1);
    chk({tag, "_idle_lo"}, 32'(bus.tx_idle), 32'd0);
    @(negedge clk);
    chk({tag, "_done_lo"}, 32'(bus.tx_done), 32'd0);
    chk({tag, "_idle_hi"}, 32'(bus.tx_idle), 32'd1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] db,
                           input logic [1:0] pm, input logic [1:0] sb,
                           input bit hold, input bit disturb, input bit brk);
    int werr;
    build(d, db, pm, sb);
    bus.din = d; bus.data_bits = db; bus.parity_mode = pm; bus.stop_bits = sb;
    bus.tx_start = 1'b1;
    bus.send_break = brk;
    @(negedge clk);
    bus.tx_start = hold;
    bus.send_break = 1'b0;
    chk({tag, "_start_tx"}, 32'(bus.tx), 32'd0);
    chk({tag, "_start_idle"}, 32'(bus.tx_idle), 32'd0);
    play(disturb, werr);
    chk({tag, "_wave"}, 32'(werr), 32'd0);
    finish_check(tag);
  endtask

  initial begin
    int werr;
    bus.s_tick = 1'b0; bus.tx_start = 1'b0; bus.din = '0; bus.data_bits = '0;
    bus.parity_mode = '0; bus.stop_bits = '0; bus.send_break = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", 32'(bus.tx), 32'd1);
    chk("rst_done", 32'(bus.tx_done), 32'd0);
    chk("rst_idle", 32'(bus.tx_idle), 32'd1);
    @(negedge clk);

    run_frame("8n1_a5", 8'hA5, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    run_frame("7e2_ff", 8'hFF, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0);
    run_frame("7o1_03", 8'h03, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);

    // Held tx_start: the second frame must start on the edge right after tx_idle rises.
    run_frame("5n15_a", 8'h1F, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
    run_frame("5n15_b", 8'($urandom), 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);

    run_frame("disturb", 8'($urandom), 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("no_second_tx", 32'(bus.tx), 32'd1);
    chk("no_second_idle", 32'(bus.tx_idle), 32'd1);

    // Break held for 100 ticks, then one bit of mark and a done pulse.
    bus.send_break = 1'b1;
    @(negedge clk);
    chk("brk_tx", 32'(bus.tx), 32'd0);
    chk("brk_idle", 32'(bus.tx_idle), 32'd0);
    exp_q.delete();
    repeat (100) exp_q.push_back(1'b0);
    play(1'b0, werr);
    chk("brk_low", 32'(werr), 32'd0);
    bus.send_break = 1'b0;
    @(negedge clk);
    chk("brk_mark_tx", 32'(bus.tx), 32'd1);
    exp_q.delete();
    repeat (OVS) exp_q.push_back(1'b1);
    play(1'b0, werr);
    chk("brk_mark", 32'(werr), 32'd0);
    finish_check("brk");

    run_frame("start_brk", 8'h5A, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("start_brk_after_tx", 32'(bus.tx), 32'd1);
    chk("start_brk_after_idle", 32'(bus.tx_idle), 32'd1);

    // Reset in the middle of the data bits aborts the frame.
    bus.din = 8'h3C; bus.data_bits = 2'b11; bus.parity_mode = 2'b00; bus.stop_bits = 2'b00;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    repeat (40) begin
      bus.s_tick = 1'b1;
      @(negedge clk);
      bus.s_tick = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx", 32'(bus.tx), 32'd1);
    chk("midrst_idle", 32'(bus.tx_idle), 32'd1);
    chk("midrst_done", 32'(bus.tx_done), 32'd0);
    run_frame("post_rst", 8'($urandom), 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("rand%0d", i), 8'($urandom), 2'($urandom), 2'($urandom),
                2'($urandom), 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
